// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
// States, opcode/funct codes, one-hot ALU operations, decode helper.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_WB_R,
        S_WB_I,
        S_BRANCH,
        S_JUMP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [7:0] ALU_ADD   = 8'h01;
    localparam logic [7:0] ALU_SUB   = 8'h02;
    localparam logic [7:0] ALU_OR    = 8'h04;
    localparam logic [7:0] ALU_AND   = 8'h08;
    localparam logic [7:0] ALU_LUI   = 8'h10;
    localparam logic [7:0] ALU_SLL   = 8'h20;
    localparam logic [7:0] ALU_SLT   = 8'h40;
    localparam logic [7:0] ALU_PASSB = 8'h80;

    // State to leave DECODE for; S_FETCH means the instruction is illegal.
    function automatic state_e decode_target(
        input logic [5:0] op,
        input logic [5:0] funct,
        input logic       r_ok
    );
        state_e tgt;
        tgt = S_FETCH;
        case (op)
            OP_RTYPE: begin
                if (r_ok)              tgt = S_EXEC_R;
                else if (funct == F_JR) tgt = S_JUMP;
            end
            OP_ORI, OP_LUI: tgt = S_EXEC_I;
            OP_LW, OP_SW:   tgt = S_MEM_ADDR;
            OP_BEQ:         tgt = S_BRANCH;
            OP_J, OP_JAL:   tgt = S_JUMP;
            default:        tgt = S_FETCH;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: opcode/funct to one-hot ALUctrl.
// Also flags which R-type functs are ALU operations.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [7:0] alu_ctrl_o,
    output logic       r_legal_o
);

    // Map the instruction to its ALU operation; ADD when nothing specific.
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        r_legal_o  = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                r_legal_o = 1'b1;
                case (funct_i)
                    F_ADDU:  alu_ctrl_o = ALU_ADD;
                    F_SUBU:  alu_ctrl_o = ALU_SUB;
                    F_AND:   alu_ctrl_o = ALU_AND;
                    F_OR:    alu_ctrl_o = ALU_OR;
                    F_SLT:   alu_ctrl_o = ALU_SLT;
                    F_SLL:   alu_ctrl_o = ALU_SLL;
                    default: r_legal_o  = 1'b0;
                endcase
            end
            OP_ORI:  alu_ctrl_o = ALU_OR;
            OP_LUI:  alu_ctrl_o = ALU_LUI;
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with memory handshake watchdog.
// Outputs follow the state and latched IR; all forced low in reset.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_srca,
    output logic [1:0]  alu_srcb,
    output logic        ext_op,
    output logic [7:0]  ALUctrl,
    output logic        illegal,
    output logic        bus_err
);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]          op, funct;
    logic [7:0]          alu_op;
    logic                r_legal;
    logic                mem_st;
    logic                timeout;
    state_e              dec_tgt;
    logic                unused_instr;

    assign op           = instr[31:26];
    assign funct        = instr[5:0];
    assign unused_instr = ^instr[25:6];

    mc_alu_dec u_alu_dec (
        .op_i       (op),
        .funct_i    (funct),
        .alu_ctrl_o (alu_op),
        .r_legal_o  (r_legal)
    );

    assign dec_tgt = decode_target(op, funct, r_legal);
    assign mem_st  = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);
    assign timeout = mem_st && !mem_ready &&
                     (cnt_q == WAIT_W'(WAIT_MAX));

    // State and watchdog counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the counter only survives while a memory wait continues.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (mem_st && !mem_ready && !timeout) cnt_d = cnt_q + 1'b1;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else if (timeout) state_d = S_FETCH;
            end
            S_DECODE:   state_d = dec_tgt;
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready) state_d = S_MEM_WB;
                else if (timeout) state_d = S_FETCH;
            end
            S_MEM_WR: begin
                if (mem_ready || timeout) state_d = S_FETCH;
            end
            S_MEM_WB, S_WB_R, S_WB_I,
            S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Control outputs per state; held at zero while reset is asserted.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        reg_we     = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_srca   = 1'b0;
        alu_srcb   = 2'b00;
        ext_op     = 1'b0;
        ALUctrl    = 8'h00;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        if (reset_n) begin
            ALUctrl = ALU_ADD;
            unique case (state_q)
                S_FETCH: begin
                    mem_req  = !timeout;
                    bus_err  = timeout;
                    alu_srcb = 2'b01;
                    ir_we    = mem_ready;
                    pc_we    = mem_ready;
                end
                S_DECODE: begin
                    alu_srcb = 2'b11;
                    illegal  = (dec_tgt == S_FETCH);
                end
                S_EXEC_R: begin
                    alu_srca = 1'b1;
                    ALUctrl  = alu_op;
                end
                S_WB_R: begin
                    reg_we  = 1'b1;
                    reg_dst = 2'b01;
                    ALUctrl = alu_op;
                end
                S_EXEC_I: begin
                    alu_srcb = 2'b10;
                    ALUctrl  = alu_op;
                end
                S_WB_I: begin
                    reg_we  = 1'b1;
                    ALUctrl = alu_op;
                end
                S_MEM_ADDR: begin
                    alu_srca = 1'b1;
                    alu_srcb = 2'b10;
                    ext_op   = 1'b1;
                end
                S_MEM_RD: begin
                    mem_req = !timeout;
                    bus_err = timeout;
                    iord    = 1'b1;
                end
                S_MEM_WB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 2'b01;
                end
                S_MEM_WR: begin
                    mem_req = !timeout;
                    mem_we  = !timeout;
                    bus_err = timeout;
                    iord    = 1'b1;
                end
                S_BRANCH: begin
                    alu_srca = 1'b1;
                    ALUctrl  = ALU_SUB;
                    pc_we    = zero;
                    pc_src   = 2'b01;
                end
                S_JUMP: begin
                    pc_we = 1'b1;
                    if (op == OP_RTYPE) begin
                        pc_src = 2'b11;
                    end else begin
                        pc_src = 2'b10;
                        if (op == OP_JAL) begin
                            reg_we     = 1'b1;
                            reg_dst    = 2'b10;
                            mem_to_reg = 2'b10;
                        end
                    end
                end
                default: ALUctrl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: expected per-cycle outputs are queued
// by the stimulus and checked on the falling edge by a monitor.
module tb_mc_ctrl;

    typedef struct packed {
        logic       rq;
        logic       we;
        logic       io;
        logic       irw;
        logic       pcw;
        logic [1:0] ps;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] mr;
        logic       sa;
        logic [1:0] sb;
        logic       ex;
        logic [7:0] al;
        logic       il;
        logic       be;
    } out_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_srcb;
    logic        reg_we, alu_srca, ext_op, illegal, bus_err;
    logic [7:0]  ALUctrl;

    out_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;

    mc_ctrl #(.WAIT_MAX(15), .WAIT_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .ext_op     (ext_op),
        .ALUctrl    (ALUctrl),
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    function automatic out_t o(
        bit rq, bit we, bit io, bit irw, bit pcw, bit [1:0] ps,
        bit rw, bit [1:0] rd, bit [1:0] mr, bit sa, bit [1:0] sb,
        bit ex, bit [7:0] al, bit il, bit be
    );
        return {rq, we, io, irw, pcw, ps, rw, rd, mr, sa, sb,
                ex, al, il, be};
    endfunction

    //        rq we io irw pcw ps rw rd mr sa sb ex al    il be
    out_t Z   = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    out_t FW  = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0);
    out_t FG  = o(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 8'h01, 0, 0);
    out_t FE  = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h01, 0, 1);
    out_t DC  = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 8'h01, 0, 0);
    out_t DI  = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 8'h01, 1, 0);
    out_t XRA = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h01, 0, 0);
    out_t WRA = o(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 8'h01, 0, 0);
    out_t XRS = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h20, 0, 0);
    out_t WRS = o(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 8'h20, 0, 0);
    out_t XIO = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 8'h04, 0, 0);
    out_t WIO = o(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h04, 0, 0);
    out_t MA  = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 8'h01, 0, 0);
    out_t MR  = o(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h01, 0, 0);
    out_t MWB = o(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 8'h01, 0, 0);
    out_t MW  = o(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h01, 0, 0);
    out_t BR1 = o(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 8'h02, 0, 0);
    out_t BR0 = o(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 8'h02, 0, 0);
    out_t JL  = o(0, 0, 0, 0, 1, 2, 1, 2, 2, 0, 0, 0, 8'h01, 0, 0);
    out_t JR  = o(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 8'h01, 0, 0);

    localparam logic [31:0] ADDU = 32'h0022_1821;
    localparam logic [31:0] LW   = 32'h8C05_0008;
    localparam logic [31:0] SW   = 32'hAC05_0008;
    localparam logic [31:0] BEQ  = 32'h1022_0004;
    localparam logic [31:0] JAL  = 32'h0C00_0010;
    localparam logic [31:0] JRR  = 32'h03E0_0008;
    localparam logic [31:0] ORI  = 32'h3422_00FF;
    localparam logic [31:0] SLL  = 32'h0002_1900;
    localparam logic [31:0] ILL  = 32'hFC00_0000;

    // One cycle: drive inputs, queue the expected outputs for this cycle.
    task automatic step(input logic [31:0] ins, input logic rs,
                        input logic z, input logic rdy,
                        input out_t e, input string nm);
        instr     = ins;
        reset_n   = rs;
        zero      = z;
        mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs with the oldest queued expectation.
    always @(negedge clk) begin
        out_t  act;
        out_t  e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we,
                   reg_dst, mem_to_reg, alu_srca, alu_srcb, ext_op,
                   ALUctrl, illegal, bus_err};
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL %s: got %h expected %h", nm, act, e);
            end
        end
    end

    initial begin
        instr     = '0;
        reset_n   = 1'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step(ADDU, 0, 0, 1, Z, "reset0");
        step(ADDU, 0, 0, 1, Z, "reset1");
        // addu
        step(ADDU, 1, 0, 1, FG,  "addu_fetch");
        step(ADDU, 1, 0, 1, DC,  "addu_dec");
        step(ADDU, 1, 0, 1, XRA, "addu_exec");
        step(ADDU, 1, 0, 1, WRA, "addu_wb");
        // lw, ready delayed 3 cycles
        step(LW, 1, 0, 1, FG, "lw_fetch");
        step(LW, 1, 0, 1, DC, "lw_dec");
        step(LW, 1, 0, 1, MA, "lw_addr");
        for (int i = 0; i < 3; i++) step(LW, 1, 0, 0, MR, "lw_rd_wait");
        step(LW, 1, 0, 1, MR,  "lw_rd_ok");
        step(LW, 1, 0, 1, MWB, "lw_wb");
        // beq taken / not taken
        step(BEQ, 1, 1, 1, FG,  "beq1_fetch");
        step(BEQ, 1, 1, 1, DC,  "beq1_dec");
        step(BEQ, 1, 1, 1, BR1, "beq_taken");
        step(BEQ, 1, 0, 1, FG,  "beq0_fetch");
        step(BEQ, 1, 0, 1, DC,  "beq0_dec");
        step(BEQ, 1, 0, 1, BR0, "beq_not_taken");
        // jal, jr
        step(JAL, 1, 0, 1, FG, "jal_fetch");
        step(JAL, 1, 0, 1, DC, "jal_dec");
        step(JAL, 1, 0, 1, JL, "jal_jump");
        step(JRR, 1, 0, 1, FG, "jr_fetch");
        step(JRR, 1, 0, 1, DC, "jr_dec");
        step(JRR, 1, 0, 1, JR, "jr_jump");
        // ori, sll
        step(ORI, 1, 0, 1, FG,  "ori_fetch");
        step(ORI, 1, 0, 1, DC,  "ori_dec");
        step(ORI, 1, 0, 1, XIO, "ori_exec");
        step(ORI, 1, 0, 1, WIO, "ori_wb");
        step(SLL, 1, 0, 1, FG,  "sll_fetch");
        step(SLL, 1, 0, 1, DC,  "sll_dec");
        step(SLL, 1, 0, 1, XRS, "sll_exec");
        step(SLL, 1, 0, 1, WRS, "sll_wb");
        // sw
        step(SW, 1, 0, 1, FG, "sw_fetch");
        step(SW, 1, 0, 1, DC, "sw_dec");
        step(SW, 1, 0, 1, MA, "sw_addr");
        step(SW, 1, 0, 1, MW, "sw_wr");
        // fetch watchdog, retry, then illegal opcode
        for (int i = 0; i < 15; i++) step(ILL, 1, 0, 0, FW, "wd_wait");
        step(ILL, 1, 0, 0, FE, "wd_bus_err");
        step(ILL, 1, 0, 0, FW, "wd_retry");
        step(ILL, 1, 0, 1, FG, "ill_fetch");
        step(ILL, 1, 0, 1, DI, "ill_dec");
        // ready on the last allowed wait cycle is a success
        step(LW, 1, 0, 1, FG, "lwe_fetch");
        step(LW, 1, 0, 1, DC, "lwe_dec");
        step(LW, 1, 0, 1, MA, "lwe_addr");
        for (int i = 0; i < 15; i++) step(LW, 1, 0, 0, MR, "lwe_wait");
        step(LW, 1, 0, 1, MR,  "lwe_edge_ok");
        step(LW, 1, 0, 1, MWB, "lwe_wb");
        // reset asserted during MEM_WR
        step(SW, 1, 0, 1, FG, "swr_fetch");
        step(SW, 1, 0, 1, DC, "swr_dec");
        step(SW, 1, 0, 1, MA, "swr_addr");
        step(SW, 1, 0, 0, MW, "swr_wr_wait");
        step(SW, 0, 0, 0, Z,  "swr_reset");
        step(SW, 0, 0, 1, Z,  "swr_reset_hold");
        step(SW, 1, 0, 0, FW, "swr_refetch");
        step(SW, 1, 0, 1, FG, "swr_refetch_go");
        // every queued expectation must have been consumed
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
